// File: rtl/data_sampler_fifo_reader.sv
// Drains a FWFT FIFO into framed records (header, NWORDS payload words, XOR trailer when DATA_SAMPLER_READER_CHECKSUM_EN is defined) on a valid/ready stream.
// One cycle from FIFO_RDEN to M_DATA; while M_VALID && !M_READY the output register holds and no pop is issued.
module data_sampler_fifo_reader #(
  parameter int         DIN_WIDTH    = 512,
  parameter int         DOUT_WIDTH   = 32,
  parameter logic [7:0] HEADER_MAGIC = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [DOUT_WIDTH-1:0] FIFO_DOUT,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RDEN,
  output logic [DOUT_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  output logic                  M_LAST,
  input  logic                  M_READY,
  output logic [15:0]           FRAME_CNT,
  output logic                  BUSY
);

  localparam int NWORDS = DIN_WIDTH / DOUT_WIDTH;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  if ((DIN_WIDTH % DOUT_WIDTH) != 0) begin : g_bad_ratio
    $error("DIN_WIDTH must be an integer multiple of DOUT_WIDTH");
  end
  if (DOUT_WIDTH < 16) begin : g_bad_width
    $error("DOUT_WIDTH must be at least 16");
  end

`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
  logic [DOUT_WIDTH-1:0]   data_d;
  logic                    valid_d;
  logic                    last_d;
  logic [15:0]             frame_cnt_d;
  logic                    adv;
  logic [DOUT_WIDTH-9:0]   hdr_cnt;
`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
  logic [DOUT_WIDTH-1:0]   checksum_q, checksum_d;
`endif

  // Output register may take a new word when empty or when its word leaves this cycle.
  assign adv     = !M_VALID || M_READY;
  assign hdr_cnt = (DOUT_WIDTH-8)'(FRAME_CNT);
  assign BUSY    = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    data_d      = M_DATA;
    valid_d     = adv ? 1'b0 : M_VALID;
    last_d      = adv ? 1'b0 : M_LAST;
    frame_cnt_d = FRAME_CNT;
    FIFO_RDEN   = 1'b0;
`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (ENABLE && !FIFO_EMPTY && adv) begin
          data_d  = {HEADER_MAGIC, hdr_cnt};
          valid_d = 1'b1;
          last_d  = 1'b0;
`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
          checksum_d = '0;
`endif
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (adv && !FIFO_EMPTY && !RESET) begin
          FIFO_RDEN = 1'b1;
          data_d    = FIFO_DOUT;
          valid_d   = 1'b1;
`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
          checksum_d = checksum_q ^ FIFO_DOUT;
`endif
          if (word_cnt_q == LAST_IDX) begin
            word_cnt_d = '0;
`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
            state_d = TRAILER;
`else
            last_d      = 1'b1;
            frame_cnt_d = FRAME_CNT + 16'd1;
            state_d     = IDLE;
`endif
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
      TRAILER: begin
        if (adv) begin
          data_d      = checksum_q;
          valid_d     = 1'b1;
          last_d      = 1'b1;
          frame_cnt_d = FRAME_CNT + 16'd1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      M_DATA     <= '0;
      M_VALID    <= 1'b0;
      M_LAST     <= 1'b0;
      FRAME_CNT  <= 16'd0;
`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      M_DATA     <= data_d;
      M_VALID    <= valid_d;
      M_LAST     <= last_d;
      FRAME_CNT  <= frame_cnt_d;
`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_sampler_fifo_reader.sv
// Directed bench for data_sampler_fifo_reader: FWFT FIFO model, stream capture and per-scenario checks.
module tb_data_sampler_fifo_reader;

`ifdef DATA_SAMPLER_READER_CHECKSUM_EN
  localparam bit HAS_TRAILER = 1'b1;
`else
  localparam bit HAS_TRAILER = 1'b0;
`endif
  localparam int FLEN = HAS_TRAILER ? 18 : 17;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, FIFO_EMPTY, FIFO_RDEN;
  logic        M_VALID, M_LAST, M_READY, BUSY;
  logic [31:0] FIFO_DOUT, M_DATA;
  logic [15:0] FRAME_CNT;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] fifo_q[$];
  logic [32:0] rx_q[$];
  int          rx_cyc[$];
  logic [32:0] exp_q[$];

  data_sampler_fifo_reader dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .FIFO_DOUT  (FIFO_DOUT),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RDEN  (FIFO_RDEN),
    .M_DATA     (M_DATA),
    .M_VALID    (M_VALID),
    .M_LAST     (M_LAST),
    .M_READY    (M_READY),
    .FRAME_CNT  (FRAME_CNT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  task automatic drive_fifo();
    FIFO_EMPTY = (fifo_q.size() == 0);
    FIFO_DOUT  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hBAD0_0000;
  endtask

  // One clock: sample at negedge, pop the model FIFO just after the posedge.
  task automatic cycle();
    logic        pop, stalled, rst_s, l;
    logic [31:0] d;
    drive_fifo();
    @(negedge CLK);
    pop     = FIFO_RDEN;
    rst_s   = RESET;
    stalled = M_VALID && !M_READY;
    d       = M_DATA;
    l       = M_LAST;
    checks++;
    if (pop && FIFO_EMPTY) begin
      errors++;
      $display("FAIL rden_when_empty: FIFO_RDEN=%b with FIFO_EMPTY=%b, required 0", pop, FIFO_EMPTY);
    end
    if (M_VALID && M_READY) begin
      rx_q.push_back({M_LAST, M_DATA});
      rx_cyc.push_back(cyc);
    end
    if (stalled) begin
      checks++;
      if (pop !== 1'b0) begin
        errors++;
        $display("FAIL rden_during_stall: FIFO_RDEN=%b, required 0", pop);
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (pop) void'(fifo_q.pop_front());
    drive_fifo();
    if (stalled && !rst_s) begin
      checks++;
      if ({M_VALID, M_LAST, M_DATA} !== {1'b1, l, d}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b l=%b d=%h, required v=1 l=%b d=%h", M_VALID, M_LAST, M_DATA, l, d);
      end
    end
  endtask

  function automatic void expect_frame(input logic [15:0] fc, input logic [31:0] base);
    logic [31:0] x;
    x = 32'h0;
    exp_q.push_back({1'b0, 8'hA5, 8'h00, fc});
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({(!HAS_TRAILER && i == 15), base + 32'(i)});
      x = x ^ (base + 32'(i));
    end
    if (HAS_TRAILER) exp_q.push_back({1'b1, x});
  endfunction

  task automatic clear_logs();
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENABLE = 1'b1; M_READY = 1'b1;
    fifo_q.delete();
    fifo_q.push_back(32'hDEAD_BEEF);
    cycle();
    cycle();
    checks++;
    if ({M_VALID, M_LAST} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: v=%b l=%b, required 0 0", M_VALID, M_LAST);
    end
    checks++;
    if (M_DATA !== 32'h0) begin
      errors++; $display("FAIL reset_data: %h, required 00000000", M_DATA);
    end
    checks++;
    if (FRAME_CNT !== 16'h0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_busy: cnt=%h busy=%b, required 0000 0", FRAME_CNT, BUSY);
    end
    checks++;
    if (FIFO_RDEN !== 1'b0 || fifo_q.size() != 1) begin
      errors++; $display("FAIL reset_rden: rden=%b fifo=%0d, required 0 1", FIFO_RDEN, fifo_q.size());
    end
    fifo_q.delete();
    RESET = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    clear_logs();
    for (int i = 0; i < 16; i++) fifo_q.push_back(32'(i));
    expect_frame(16'h0000, 32'h0);
    for (int i = 0; i < 80 && rx_q.size() < FLEN; i++) cycle();
    cycle(); cycle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_len: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < rx_cyc.size(); i++) begin
      checks++;
      if (rx_cyc[i] != rx_cyc[0] + i) begin
        errors++; $display("FAIL basic_rate%0d: cycle %0d, required %0d", i, rx_cyc[i], rx_cyc[0] + i);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'd1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL basic_cnt: cnt=%h busy=%b, required 0001 0", FRAME_CNT, BUSY);
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    for (int i = 0; i < 16; i++) fifo_q.push_back(32'(i));
    expect_frame(16'h0001, 32'h0);
    for (int i = 0; i < 160 && rx_q.size() < FLEN; i++) begin
      M_READY = !i[0];
      cycle();
    end
    M_READY = 1'b1;
    cycle(); cycle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_len: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'd2) begin
      errors++; $display("FAIL bp_cnt: %h, required 0002", FRAME_CNT);
    end
  endtask

  task automatic test_underflow();
    clear_logs();
    for (int i = 0; i < 5; i++) fifo_q.push_back(32'h100 + 32'(i));
    expect_frame(16'h0002, 32'h100);
    for (int i = 0; i < 40 && rx_q.size() < 6; i++) cycle();
    for (int g = 0; g < 10; g++) begin
      checks++;
      if (M_VALID !== 1'b0 || BUSY !== 1'b1) begin
        errors++; $display("FAIL gap%0d: v=%b busy=%b, required 0 1", g, M_VALID, BUSY);
      end
      cycle();
    end
    checks++;
    if (rx_q.size() != 6) begin
      errors++; $display("FAIL gap_count: %0d words before refill, required 6", rx_q.size());
    end
    for (int i = 5; i < 16; i++) fifo_q.push_back(32'h100 + 32'(i));
    for (int i = 0; i < 80 && rx_q.size() < FLEN; i++) cycle();
    cycle(); cycle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL uf_len: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL uf_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'd3) begin
      errors++; $display("FAIL uf_cnt: %h, required 0003", FRAME_CNT);
    end
  endtask

  task automatic test_back_to_back();
    RESET = 1'b1; cycle(); RESET = 1'b0;
    clear_logs();
    for (int i = 0; i < 48; i++) fifo_q.push_back(32'h200 + 32'(i));
    for (int f = 0; f < 3; f++) expect_frame(16'(f), 32'h200 + 32'(16 * f));
    for (int i = 0; i < 200 && rx_q.size() < 3 * FLEN; i++) cycle();
    cycle(); cycle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_len: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < rx_cyc.size(); i++) begin
      checks++;
      if (rx_cyc[i] != rx_cyc[0] + i) begin
        errors++; $display("FAIL b2b_rate%0d: cycle %0d, required %0d", i, rx_cyc[i], rx_cyc[0] + i);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'd3) begin
      errors++; $display("FAIL b2b_cnt: %h, required 0003", FRAME_CNT);
    end

    RESET = 1'b1; cycle(); RESET = 1'b0;
    clear_logs();
    for (int i = 0; i < 48; i++) fifo_q.push_back(32'h300 + 32'(i));
    for (int f = 0; f < 2; f++) expect_frame(16'(f), 32'h300 + 32'(16 * f));
    for (int i = 0; i < 100 && rx_q.size() < FLEN + 5; i++) cycle();
    ENABLE = 1'b0;
    for (int i = 0; i < 100; i++) cycle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL en_len: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL en_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'd2 || BUSY !== 1'b0 || fifo_q.size() != 16) begin
      errors++;
      $display("FAIL en_stop: cnt=%h busy=%b fifo=%0d, required 0002 0 16", FRAME_CNT, BUSY, fifo_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'h330 + 32'(i));
    ENABLE = 1'b1;
    for (int i = 0; i < 60 && rx_q.size() < 8; i++) cycle();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    checks++;
    if (M_VALID !== 1'b0 || M_LAST !== 1'b0 || FRAME_CNT !== 16'h0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: v=%b l=%b cnt=%h busy=%b, required 0 0 0000 0", M_VALID, M_LAST, FRAME_CNT, BUSY);
    end
    checks++;
    if (fifo_q.size() != 16 || fifo_q[0] !== 32'h328) begin
      errors++; $display("FAIL midrst_head: fifo=%0d head=%h, required 16 00000328", fifo_q.size(), fifo_q[0]);
    end
    clear_logs();
    expect_frame(16'h0000, 32'h328);
    for (int i = 0; i < 80 && rx_q.size() < FLEN; i++) cycle();
    cycle(); cycle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_len: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'd1) begin
      errors++; $display("FAIL midrst_cnt: %h, required 0001", FRAME_CNT);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    ENABLE = 1'b0;
    cycle();
    force dut.FRAME_CNT = 16'hFFFF;
    cycle();
    release dut.FRAME_CNT;
    cycle();
    checks++;
    if (FRAME_CNT !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preset: %h, required FFFF", FRAME_CNT);
    end
    clear_logs();
    for (int i = 0; i < 16; i++) fifo_q.push_back(32'h400 + 32'(i));
    expect_frame(16'hFFFF, 32'h400);
    ENABLE = 1'b1;
    for (int i = 0; i < 80 && rx_q.size() < FLEN; i++) cycle();
    cycle(); cycle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_len: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (FRAME_CNT !== 16'h0000) begin
      errors++; $display("FAIL wrap_cnt: %h, required 0000", FRAME_CNT);
    end
  endtask

  initial begin
    RESET      = 1'b1;
    ENABLE     = 1'b0;
    M_READY    = 1'b1;
    FIFO_EMPTY = 1'b1;
    FIFO_DOUT  = 32'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
